// File: rtl/word_collector_if.sv
// Part/word handshake bundle for word_collector: upstream narrow parts in,
// assembled wide word out. "slave" is the collector's view, "master" the surroundings'.
interface word_collector_if #(
   parameter int PART_WIDTH = 8,
   parameter int NUM_PARTS  = 4
);
   logic [PART_WIDTH-1:0]           i_part;
   logic                            i_part_valid;
   logic                            o_part_ready;
   logic [PART_WIDTH*NUM_PARTS-1:0] o_word;
   logic                            o_word_valid;
   logic                            i_word_ready;

   modport slave (
      input  i_part,
      input  i_part_valid,
      output o_part_ready,
      output o_word,
      output o_word_valid,
      input  i_word_ready
   );

   modport master (
      output i_part,
      output i_part_valid,
      input  o_part_ready,
      input  o_word,
      input  o_word_valid,
      output i_word_ready
   );
endinterface

// File: rtl/word_collector.sv
// Collects NUM_PARTS narrow parts (part 0 in the LSBs) into one wide word and holds it
// until downstream takes it. Define WORD_COLLECTOR_FRAME_CNT_EN to add o_frame_cnt.
module word_collector #(
   parameter int PART_WIDTH = 8,
   parameter int NUM_PARTS  = 4
) (
   input  logic         i_clk,
   input  logic         reset,
   word_collector_if.slave bus
`ifdef WORD_COLLECTOR_FRAME_CNT_EN
   ,
   output logic [15:0]  o_frame_cnt
`endif
);

   localparam int CNT_W = $clog2(NUM_PARTS);
   localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(NUM_PARTS - 1);

   typedef enum logic {
      COLLECT = 1'b0,
      HOLD    = 1'b1
   } state_t;

   state_t           state_reg;
   state_t           state_next;
   logic [CNT_W-1:0] idx_reg;
   logic [CNT_W-1:0] idx_next;
   logic             accept;
   logic             handshake;

   logic [PART_WIDTH-1:0] part_reg [NUM_PARTS];

   always_ff @(posedge i_clk) begin
      if (reset) begin
         state_reg <= COLLECT;
         idx_reg   <= '0;
      end else begin
         state_reg <= state_next;
         idx_reg   <= idx_next;
      end
   end

   always_comb begin
      state_next = state_reg;
      idx_next   = idx_reg;
      accept     = 1'b0;
      handshake  = 1'b0;
      case (state_reg)
         COLLECT: begin
            if (bus.i_part_valid) begin
               accept = 1'b1;
               if (idx_reg == LAST_IDX) begin
                  idx_next   = '0;
                  state_next = HOLD;
               end else begin
                  idx_next = idx_reg + CNT_W'(1);
               end
            end
         end
         HOLD: begin
            // The handshake cycle never accepts a part: one bubble per word.
            if (bus.i_word_ready) begin
               handshake  = 1'b1;
               state_next = COLLECT;
            end
         end
         default: state_next = COLLECT;
      endcase
   end

   // Reset forces COLLECT behaviour combinationally so the reset cycle itself
   // shows ready and never exposes a stale held word.
   assign bus.o_part_ready = (state_reg == COLLECT) || reset;
   assign bus.o_word_valid = (state_reg == HOLD) && !reset;

   // Each slot only loads on its own index; untouched slots keep the old word.
   generate
      for (genvar gi = 0; gi < NUM_PARTS; gi++) begin : g_slot
         always_ff @(posedge i_clk) begin
            if (reset) begin
               part_reg[gi] <= '0;
            end else if (accept && (idx_reg == CNT_W'(gi))) begin
               part_reg[gi] <= bus.i_part;
            end
         end
         assign bus.o_word[gi*PART_WIDTH +: PART_WIDTH] = part_reg[gi];
      end
   endgenerate

`ifdef WORD_COLLECTOR_FRAME_CNT_EN
   logic [15:0] frame_cnt_reg;

   always_ff @(posedge i_clk) begin
      if (reset) begin
         frame_cnt_reg <= '0;
      end else if (handshake) begin
         frame_cnt_reg <= frame_cnt_reg + 16'd1;
      end
   end

   assign o_frame_cnt = frame_cnt_reg;
`endif

endmodule

// File: tb/tb_word_collector.sv
// Bench for word_collector: directed scenarios plus random traffic, checked every
// cycle against a queue-based model of word assembly.
module tb_word_collector;
   localparam int PW = 8;
   localparam int NP = 4;
   localparam int WW = PW * NP;

   logic clk = 1'b0;
   logic rst;
   logic [15:0] frame_cnt;

   word_collector_if #(.PART_WIDTH(PW), .NUM_PARTS(NP)) bus ();

   word_collector #(.PART_WIDTH(PW), .NUM_PARTS(NP)) dut (
      .i_clk (clk),
      .reset (rst),
      .bus   (bus)
`ifdef WORD_COLLECTOR_FRAME_CNT_EN
      ,
      .o_frame_cnt (frame_cnt)
`endif
   );

`ifndef WORD_COLLECTOR_FRAME_CNT_EN
   assign frame_cnt = 16'd0;
`endif

   always #5 clk = ~clk;

   int total = 0;
   int bad   = 0;

   // Reference model: accepted parts of the current word sit in a queue; the
   // visible word is the previous word with those slots overwritten.
   bit              holding = 1'b0;
   logic [WW-1:0]   prev_word = '0;
   logic [PW-1:0]   q[$];
   logic [15:0]     mdl_frame = '0;
   int              dut_acc = 0;
   bit              verbose = 1'b1;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [WW-1:0] exp_word();
      logic [WW-1:0] w;
      w = prev_word;
      for (int k = 0; k < q.size(); k++) w[k*PW +: PW] = q[k];
      return w;
   endfunction

   task automatic step(input bit v, input logic [PW-1:0] p, input bit wr, input bit r);
      bus.i_part_valid = v;
      bus.i_part       = p;
      bus.i_word_ready = wr;
      rst              = r;
      #1;
      check_eq("ready_pre", 64'(bus.o_part_ready), 64'(!holding || r));
      check_eq("valid_pre", 64'(bus.o_word_valid), 64'(holding && !r));
      if (v && bus.o_part_ready && !r) dut_acc++;
      @(posedge clk);
      if (r) begin
         q.delete();
         prev_word = '0;
         holding   = 1'b0;
         mdl_frame = '0;
      end else if (holding) begin
         if (wr) begin
            holding   = 1'b0;
            mdl_frame = mdl_frame + 16'd1;
         end
      end else if (v) begin
         q.push_back(p);
         if (q.size() == NP) begin
            prev_word = exp_word();
            q.delete();
            holding = 1'b1;
            if (verbose) $display("word complete %08h", prev_word);
         end
      end
      #1;
      check_eq("ready", 64'(bus.o_part_ready), 64'(!holding));
      check_eq("valid", 64'(bus.o_word_valid), 64'(holding));
      check_eq("word", 64'(bus.o_word), 64'(exp_word()));
`ifdef WORD_COLLECTOR_FRAME_CNT_EN
      check_eq("frame_cnt", 64'(frame_cnt), 64'(mdl_frame));
`endif
   endtask

   initial begin
      logic [PW-1:0] pat [4];
      int acc0;
      int gaps;

      bus.i_part_valid = 1'b0;
      bus.i_part       = '0;
      bus.i_word_ready = 1'b0;
      rst              = 1'b1;

      // Reset state
      step(1'b0, 8'h00, 1'b0, 1'b1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_eq("rst_word", 64'(bus.o_word), 64'd0);
      step(1'b0, 8'h00, 1'b0, 1'b0);

      // Back-to-back parts -> 44332211 valid the cycle after the last part
      pat[0] = 8'h11; pat[1] = 8'h22; pat[2] = 8'h33; pat[3] = 8'h44;
      for (int i = 0; i < 4; i++) step(1'b1, pat[i], 1'b1, 1'b0);
      check_eq("b2b_valid", 64'(bus.o_word_valid), 64'd1);
      check_eq("b2b_word", 64'(bus.o_word), 64'h44332211);

      // Stalled in HOLD with upstream still pushing
      for (int i = 0; i < 5; i++) begin
         step(1'b1, 8'(i + 8'h50), 1'b0, 1'b0);
         check_eq("hold_word", 64'(bus.o_word), 64'h44332211);
         check_eq("hold_ready", 64'(bus.o_part_ready), 64'd0);
      end
      step(1'b1, 8'h99, 1'b1, 1'b0);
      check_eq("release_valid", 64'(bus.o_word_valid), 64'd0);
      check_eq("release_ready", 64'(bus.o_part_ready), 64'd1);

      // All-ones parts with random idle gaps
      acc0 = dut_acc;
      for (int i = 0; i < 4; i++) begin
         gaps = $urandom_range(0, 4);
         for (int g = 0; g < gaps; g++) step(1'b0, 8'($urandom), 1'($urandom), 1'b0);
         step(1'b1, 8'hFF, 1'b0, 1'b0);
      end
      check_eq("ff_word", 64'(bus.o_word), 64'hFFFFFFFF);
      check_eq("ff_count", 64'(dut_acc - acc0), 64'd4);
      step(1'b0, 8'h00, 1'b1, 1'b0);

      // Reset mid-word, then a fresh word
      step(1'b1, 8'hB1, 1'b0, 1'b0);
      step(1'b1, 8'hB2, 1'b0, 1'b0);
      step(1'b1, 8'hB3, 1'b0, 1'b1);
      for (int i = 0; i < 4; i++) begin
         step(1'b1, 8'(8'hA1 + i), 1'b0, 1'b0);
         if (i < 3) check_eq("midrst_novalid", 64'(bus.o_word_valid), 64'd0);
      end
      check_eq("midrst_word", 64'(bus.o_word), 64'hA4A3A2A1);

      // Reset while holding
      step(1'b1, 8'h00, 1'b1, 1'b1);
      check_eq("holdrst_valid", 64'(bus.o_word_valid), 64'd0);
      check_eq("holdrst_word", 64'(bus.o_word), 64'd0);

      // Random traffic
      for (int i = 0; i < 3000; i++) begin
         step($urandom_range(0, 3) != 0, 8'($urandom), $urandom_range(0, 2) == 0,
              $urandom_range(0, 199) == 0);
      end

`ifdef WORD_COLLECTOR_FRAME_CNT_EN
      // Frame counter wrap: 65537 handshakes from reset end at 1
      verbose = 1'b0;
      step(1'b0, 8'h00, 1'b0, 1'b1);
      for (int n = 0; n < 65537; n++) begin
         for (int i = 0; i < 4; i++) step(1'b1, 8'($urandom), 1'b0, 1'b0);
         step(1'b0, 8'h00, 1'b1, 1'b0);
      end
      check_eq("frame_wrap", 64'(frame_cnt), 64'd1);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
